// File: rtl/pwm_gen_core_if.sv
// Static configuration and status bundle between the PWM register file (master)
// and the PWM generation core (slave).
interface pwm_gen_core_if #(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] cfg_ctrl;
  logic [DATA_W-1:0] cfg_prescale;
  logic [DATA_W-1:0] cfg_period;
  logic [DATA_W-1:0] cfg_duty;
  logic              irq_clr;
  logic              pwm_out;
  logic              period_tick;
  logic              irq;
  logic [CNT_W-1:0]  cnt_value;

  modport master (
    output cfg_ctrl, cfg_prescale, cfg_period, cfg_duty, irq_clr,
    input  pwm_out, period_tick, irq, cnt_value
  );

  modport slave (
    input  cfg_ctrl, cfg_prescale, cfg_period, cfg_duty, irq_clr,
    output pwm_out, period_tick, irq, cnt_value
  );
endinterface

// File: rtl/pwm_gen_core.sv
// Double-buffered PWM generator: prescaler, period counter, shadowed duty compare,
// period-end pulse and sticky interrupt.
module pwm_gen_core #(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset_p,
  pwm_gen_core_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] psc_sh_q, psc_sh_d;
  logic [CNT_W-1:0] per_sh_q, per_sh_d;
  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic             pwm_out_q, pwm_out_d;
  logic             period_tick_q, period_tick_d;
  logic             irq_q, irq_d;

  logic             en_s, inv_s, irq_en_s;
  logic             tick_s, wrap_s;
  logic [CNT_W-1:0] cfg_psc_s, cfg_per_s, cfg_duty_s;

  assign en_s       = bus.cfg_ctrl[0];
  assign inv_s      = bus.cfg_ctrl[1];
  assign irq_en_s   = bus.cfg_ctrl[2];
  assign cfg_psc_s  = bus.cfg_prescale[CNT_W-1:0];
  assign cfg_per_s  = bus.cfg_period[CNT_W-1:0];
  assign cfg_duty_s = bus.cfg_duty[CNT_W-1:0];

  // Upper configuration bits carry no meaning for this core.
  generate
    if (DATA_W > CNT_W) begin : g_unused_hi
      logic unused_hi_s;
      assign unused_hi_s = ^{bus.cfg_ctrl[DATA_W-1:3], bus.cfg_prescale[DATA_W-1:CNT_W],
                             bus.cfg_period[DATA_W-1:CNT_W], bus.cfg_duty[DATA_W-1:CNT_W]};
    end else begin : g_unused_ctrl
      logic unused_ctrl_s;
      assign unused_ctrl_s = ^bus.cfg_ctrl[DATA_W-1:3];
    end
  endgenerate

  assign tick_s = (psc_cnt_q == psc_sh_q);
  assign wrap_s = tick_s && (per_cnt_q == per_sh_q);

  // Next-state, counter, shadow and output decode.
  always_comb begin
    state_d       = state_q;
    psc_cnt_d     = psc_cnt_q;
    per_cnt_d     = per_cnt_q;
    psc_sh_d      = psc_sh_q;
    per_sh_d      = per_sh_q;
    duty_sh_d     = duty_sh_q;
    pwm_out_d     = inv_s;
    period_tick_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        psc_cnt_d = CNT_ZERO;
        per_cnt_d = CNT_ZERO;
        if (en_s) begin
          state_d   = ST_RUN;
          psc_sh_d  = cfg_psc_s;
          per_sh_d  = cfg_per_s;
          duty_sh_d = cfg_duty_s;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!en_s) begin
          // Stopping clears the counters and drops any pending period pulse.
          state_d   = ST_IDLE;
          psc_cnt_d = CNT_ZERO;
          per_cnt_d = CNT_ZERO;
        end else begin
          pwm_out_d = (per_cnt_q < duty_sh_q) ^ inv_s;
          if (wrap_s) begin
            psc_cnt_d     = CNT_ZERO;
            per_cnt_d     = CNT_ZERO;
            psc_sh_d      = cfg_psc_s;
            per_sh_d      = cfg_per_s;
            duty_sh_d     = cfg_duty_s;
            period_tick_d = 1'b1;
          end else if (tick_s) begin
            psc_cnt_d = CNT_ZERO;
            per_cnt_d = per_cnt_q + CNT_ONE;
          end else begin
            psc_cnt_d = psc_cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psc_cnt_d = CNT_ZERO;
        per_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // Sticky interrupt: a set on the same edge as a clear takes priority.
  always_comb begin
    if (period_tick_d && irq_en_s) begin
      irq_d = 1'b1;
    end else if (bus.irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q       <= ST_IDLE;
      psc_cnt_q     <= CNT_ZERO;
      per_cnt_q     <= CNT_ZERO;
      psc_sh_q      <= CNT_ZERO;
      per_sh_q      <= CNT_ZERO;
      duty_sh_q     <= CNT_ZERO;
      pwm_out_q     <= 1'b0;
      period_tick_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      psc_cnt_q     <= psc_cnt_d;
      per_cnt_q     <= per_cnt_d;
      psc_sh_q      <= psc_sh_d;
      per_sh_q      <= per_sh_d;
      duty_sh_q     <= duty_sh_d;
      pwm_out_q     <= pwm_out_d;
      period_tick_q <= period_tick_d;
      irq_q         <= irq_d;
    end
  end

  assign bus.pwm_out     = pwm_out_q;
  assign bus.period_tick = period_tick_q;
  assign bus.irq         = irq_q;
  assign bus.cnt_value   = per_cnt_q;

endmodule

// File: tb/tb_pwm_gen_core.sv
// Randomized and directed bench for pwm_gen_core against an elapsed-time reference model.
module tb_pwm_gen_core;
  localparam int CNT_W  = 16;
  localparam int DATA_W = 32;
  localparam int VW     = CNT_W + 3;

  logic clk = 1'b0;
  logic reset_p;
  int   n_cmp  = 0;
  int   n_fail = 0;

  pwm_gen_core_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();

  pwm_gen_core #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: position inside the period as elapsed clocks, shadow config as integers.
  bit     m_run, m_pwm, m_tick, m_irq;
  longint m_el, m_cnt, s_psc, s_per, s_duty;

  function automatic logic [VW-1:0] exp_vec();
    logic [CNT_W-1:0] c;
    c = m_cnt[CNT_W-1:0];
    return {m_pwm, m_tick, m_irq, c};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.pwm_out, bus.period_tick, bus.irq, bus.cnt_value};
  endfunction

  function automatic longint plen();
    return (s_psc + 1) * (s_per + 1);
  endfunction

  task automatic load_shadows();
    s_psc  = longint'(bus.cfg_prescale[CNT_W-1:0]);
    s_per  = longint'(bus.cfg_period[CNT_W-1:0]);
    s_duty = longint'(bus.cfg_duty[CNT_W-1:0]);
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then settle.
  task automatic cyc();
    bit en, inv, ie, clr;
    @(posedge clk);
    en  = bus.cfg_ctrl[0];
    inv = bus.cfg_ctrl[1];
    ie  = bus.cfg_ctrl[2];
    clr = bus.irq_clr;
    if (reset_p) begin
      m_run = 1'b0; m_pwm = 1'b0; m_tick = 1'b0; m_irq = 1'b0;
      m_el = 0; s_psc = 0; s_per = 0; s_duty = 0;
    end else if (m_run && en) begin
      m_pwm = ((m_el / (s_psc + 1)) < s_duty) ^ inv;
      if (m_el == plen() - 1) begin
        m_tick = 1'b1;
        m_el   = 0;
        load_shadows();
      end else begin
        m_tick = 1'b0;
        m_el   = m_el + 1;
      end
      m_irq = (m_tick & ie) | (m_irq & ~clr);
    end else begin
      if (!m_run && en) load_shadows();
      m_run  = en;
      m_el   = 0;
      m_pwm  = inv;
      m_tick = 1'b0;
      m_irq  = m_irq & ~clr;
    end
    m_cnt = m_el / (s_psc + 1);
    #1;
  endtask

  task automatic set_cfg(input bit en, input bit inv, input bit ie,
                         input int psc, input int per, input int duty);
    bus.cfg_ctrl     = {29'($urandom), ie, inv, en};
    bus.cfg_prescale = {16'($urandom), 16'(psc)};
    bus.cfg_period   = {16'($urandom), 16'(per)};
    bus.cfg_duty     = {16'($urandom), 16'(duty)};
  endtask

  task automatic set_ctrl(input bit en, input bit inv, input bit ie);
    bus.cfg_ctrl = {29'($urandom), ie, inv, en};
  endtask

  task automatic test_reset();
    set_cfg(1'b1, 1'b1, 1'b1, 0, 3, 2);
    bus.irq_clr = 1'b0;
    reset_p = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (obs_vec() !== {VW{1'b0}}) begin
        n_fail++;
        $display("FAIL reset_values got=%h want=%h", obs_vec(), {VW{1'b0}});
      end
    end
    set_ctrl(1'b0, 1'b1, 1'b0);
    reset_p = 1'b0;
    cyc();
    n_cmp++;
    if (bus.pwm_out !== 1'b1 || bus.cnt_value !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_follows_inv got pwm=%b cnt=%0d want pwm=1 cnt=0", bus.pwm_out, bus.cnt_value);
    end
    set_ctrl(1'b0, 1'b0, 1'b0);
    cyc();
  endtask

  task automatic test_basic();
    int hi, guard;
    set_cfg(1'b1, 1'b0, 1'b0, 0, 9, 3);
    guard = 0;
    do begin
      cyc();
      guard++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic_model got=%h want=%h", obs_vec(), exp_vec());
      end
    end while (bus.period_tick !== 1'b1 && guard < 40);
    if (guard >= 40) begin
      n_cmp++; n_fail++;
      $display("FAIL basic_tick_timeout got no period_tick in 40 clocks want one");
    end
    for (int p = 0; p < 2; p++) begin
      hi = 0;
      for (int i = 1; i <= 10; i++) begin
        cyc();
        hi += int'(bus.pwm_out);
        n_cmp++;
        if (bus.cnt_value !== 16'(i % 10) || bus.period_tick !== (i == 10)) begin
          n_fail++;
          $display("FAIL basic_seq got cnt=%0d tick=%b want cnt=%0d tick=%b",
                   bus.cnt_value, bus.period_tick, i % 10, i == 10);
        end
      end
      n_cmp++;
      if (hi !== 3) begin
        n_fail++;
        $display("FAIL basic_high_time got=%0d want=3", hi);
      end
    end
  endtask

  task automatic test_prescale();
    int hi;
    set_cfg(1'b0, 1'b0, 1'b0, 1, 4, 2);
    cyc();
    set_ctrl(1'b1, 1'b0, 1'b0);
    cyc();
    hi = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      hi += int'(bus.pwm_out);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL psc_model got=%h want=%h", obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (hi !== 4 || bus.period_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL psc_high_period got hi=%0d tick=%b want hi=4 tick=1", hi, bus.period_tick);
    end
    cyc(); cyc();
    set_ctrl(1'b1, 1'b1, 1'b0);
    cyc();
    n_cmp++;
    if (bus.pwm_out !== 1'b0 || bus.cnt_value !== 16'd1) begin
      n_fail++;
      $display("FAIL psc_invert got pwm=%b cnt=%0d want pwm=0 cnt=1", bus.pwm_out, bus.cnt_value);
    end
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL psc_inv_model got=%h want=%h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_shadow();
    int hi0, hi1, guard;
    set_cfg(1'b0, 1'b0, 1'b0, 0, 9, 3);
    cyc();
    set_ctrl(1'b1, 1'b0, 1'b0);
    guard = 0;
    do begin cyc(); guard++; end while (bus.period_tick !== 1'b1 && guard < 30);
    if (guard >= 30) begin
      n_cmp++; n_fail++;
      $display("FAIL shadow_tick_timeout got no period_tick want one");
    end
    hi0 = 0; hi1 = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i <= 10) hi0 += int'(bus.pwm_out);
      else hi1 += int'(bus.pwm_out);
      if (i == 5) bus.cfg_duty = {16'($urandom), 16'd7};
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL shadow_model got=%h want=%h", obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (hi0 !== 3 || hi1 !== 7) begin
      n_fail++;
      $display("FAIL shadow_duty got hi=%0d,%0d want 3,7", hi0, hi1);
    end
  endtask

  task automatic test_boundary();
    int ticks, bad;
    for (int k = 0; k < 2; k++) begin
      set_cfg(1'b0, 1'b0, 1'b0, 0, 9, (k == 0) ? 0 : 12);
      cyc();
      set_ctrl(1'b1, 1'b0, 1'b0);
      cyc();
      ticks = 0; bad = 0;
      for (int i = 1; i <= 25; i++) begin
        cyc();
        ticks += int'(bus.period_tick);
        if (bus.pwm_out !== (k == 1)) bad++;
      end
      n_cmp++;
      if (ticks !== 2 || bad !== 0) begin
        n_fail++;
        $display("FAIL boundary_duty%0d got ticks=%0d badpwm=%0d want ticks=2 badpwm=0",
                 k, ticks, bad);
      end
    end
    set_cfg(1'b0, 1'b0, 1'b0, 0, 16'hFFFF, 16'h0020);
    cyc();
    set_ctrl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      cyc();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL boundary_maxper got=%h want=%h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_irq();
    int guard;
    set_cfg(1'b0, 1'b0, 1'b1, 0, 9, 3);
    bus.irq_clr = 1'b1;
    cyc();
    bus.irq_clr = 1'b0;
    set_ctrl(1'b1, 1'b0, 1'b1);
    guard = 0;
    do begin cyc(); guard++; end while (bus.period_tick !== 1'b1 && guard < 30);
    n_cmp++;
    if (bus.irq !== 1'b1 || guard >= 30) begin
      n_fail++;
      $display("FAIL irq_first_set got irq=%b tick=%b want irq=1 tick=1", bus.irq, bus.period_tick);
    end
    guard = 0;
    while (!(m_el == plen() - 1) && guard < 30) begin cyc(); guard++; end
    bus.irq_clr = 1'b1;
    cyc();
    bus.irq_clr = 1'b0;
    n_cmp++;
    if (bus.irq !== 1'b1 || bus.period_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set_wins got irq=%b tick=%b want irq=1 tick=1", bus.irq, bus.period_tick);
    end
    cyc();
    bus.irq_clr = 1'b1;
    cyc();
    bus.irq_clr = 1'b0;
    n_cmp++;
    if (bus.irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear got=%b want=0", bus.irq);
    end
    set_ctrl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      cyc();
      n_cmp++;
      if (bus.irq !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL irq_disabled got=%h want=%h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_disable_reset();
    int guard, ticks;
    set_cfg(1'b1, 1'b0, 1'b0, 0, 9, 3);
    guard = 0;
    do begin cyc(); guard++; end while (bus.cnt_value !== 16'd4 && guard < 30);
    set_ctrl(1'b0, 1'b0, 1'b0);
    cyc();
    n_cmp++;
    if (bus.pwm_out !== 1'b0 || bus.cnt_value !== 16'd0 || bus.period_tick !== 1'b0 || guard >= 30) begin
      n_fail++;
      $display("FAIL disable got pwm=%b cnt=%0d tick=%b want 0 0 0",
               bus.pwm_out, bus.cnt_value, bus.period_tick);
    end
    ticks = 0;
    for (int i = 0; i < 12; i++) begin cyc(); ticks += int'(bus.period_tick); end
    n_cmp++;
    if (ticks !== 0) begin
      n_fail++;
      $display("FAIL disable_no_tick got=%0d want=0", ticks);
    end
    set_ctrl(1'b1, 1'b0, 1'b0);
    cyc();
    cyc();
    n_cmp++;
    if (bus.pwm_out !== 1'b1 || bus.cnt_value !== 16'd1) begin
      n_fail++;
      $display("FAIL reenable got pwm=%b cnt=%0d want pwm=1 cnt=1", bus.pwm_out, bus.cnt_value);
    end
    set_ctrl(1'b1, 1'b1, 1'b1);
    cyc(); cyc(); cyc();
    reset_p = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_cmp++;
      if (obs_vec() !== {VW{1'b0}}) begin
        n_fail++;
        $display("FAIL reset_midrun got=%h want=%h", obs_vec(), {VW{1'b0}});
      end
    end
    reset_p = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_restart got=%h want=%h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0)
        set_cfg(bus.cfg_ctrl[0], bus.cfg_ctrl[1], bus.cfg_ctrl[2],
                $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 20));
      if ($urandom_range(0, 59) == 0) set_ctrl(~bus.cfg_ctrl[0], bus.cfg_ctrl[1], bus.cfg_ctrl[2]);
      if ($urandom_range(0, 49) == 0) set_ctrl(bus.cfg_ctrl[0], 1'($urandom), 1'($urandom));
      bus.irq_clr = ($urandom_range(0, 7) == 0);
      reset_p     = ($urandom_range(0, 399) == 0);
      cyc();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    reset_p     = 1'b0;
    bus.irq_clr = 1'b0;
  endtask

  initial begin
    reset_p = 1'b1;
    bus.irq_clr = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0, 0, 0, 0);
    m_run = 1'b0; m_pwm = 1'b0; m_tick = 1'b0; m_irq = 1'b0;
    m_el = 0; m_cnt = 0; s_psc = 0; s_per = 0; s_duty = 0;
    test_reset();
    test_basic();
    test_prescale();
    test_shadow();
    test_boundary();
    test_irq();
    test_disable_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_gen_core.md
# pwm_gen_core

PWM generation core that sits directly downstream of the AXI4-Lite slave register file in the PWM IP. It consumes the four 32-bit slave registers (control, prescale, period, duty) as static configuration and produces a glitch-free, double-buffered PWM waveform plus a period-end pulse and a sticky interrupt. It has no bus logic; the register file drives its inputs continuously and routes `irq_clr` from a write-one-to-clear decode.

## Interface
- `CNT_W`, 16: width of prescale, period and duty counters; legal 8..32.
- `DATA_W`, 32: width of each configuration register input.

- `clk`  in  1  system clock, rising edge.
- `reset_p`  in  1  synchronous active-high reset.
- `cfg_ctrl`  in  DATA_W  bit0 `en`, bit1 `inv` (output polarity), bit2 `irq_en`; other bits ignored.
- `cfg_prescale`  in  DATA_W  bits [CNT_W-1:0] used; a tick occurs every `prescale+1` clocks.
- `cfg_period`  in  DATA_W  bits [CNT_W-1:0] used; the period is `period+1` ticks.
- `cfg_duty`  in  DATA_W  bits [CNT_W-1:0] used; the high time is `duty` ticks.
- `irq_clr`  in  1  single-cycle pulse that clears `irq`.
- `pwm_out`  out  1  registered PWM output.
- `period_tick`  out  1  registered one-clock pulse per completed period.
- `irq`  out  1  sticky interrupt.
- `cnt_value`  out  CNT_W  current period counter, for status readback.

## Operation
- Two states:
  - IDLE (reset state).
  - RUN.
- IDLE:
  - `psc_cnt` and `per_cnt` are held at 0.
  - `pwm_out` = `inv`.
  - `period_tick` = 0.
  - IDLE -> RUN on the first clock with `en`=1.
  - That same edge loads the shadow registers `psc_sh`, `per_sh`, `duty_sh` from the cfg inputs.
  - It also sets `psc_cnt`=0 and `per_cnt`=0.
- RUN:
  - `tick` = (`psc_cnt` == `psc_sh`).
  - On tick, `psc_cnt` returns to 0; otherwise it increments.
  - On tick with `per_cnt` == `per_sh` (wrap):
    - `per_cnt` returns to 0.
    - The shadows reload from the cfg inputs.
    - `period_tick` is asserted on the next edge.
  - On tick without wrap, `per_cnt` increments.
- RUN -> IDLE on any clock with `en`=0. Counters clear on that edge; they are not frozen mid-count.
- Output: `pwm_out` <= RUN ? ((`per_cnt` < `duty_sh`) ^ `inv`) : `inv`.
  - The compare is unsigned at CNT_W bits.
  - `inv` is live, not shadowed.
  - `duty`=0 gives a constant `inv` output.
  - `duty` > `per_sh` gives a constant `~inv` output (100%).
- Shadowing:
  - Writes to prescale, period or duty take effect only at the next wrap or at IDLE->RUN.
  - No partial or glitched periods occur.
- Interrupt:
  - `irq` is set on the edge where `period_tick` is asserted, if `irq_en`=1.
  - `irq` is cleared by `irq_clr`.
  - If set and clear occur on the same edge, set wins.
  - `irq_en`=0 does not clear a pending `irq`.
- `cnt_value` = `per_cnt` (registered). It is 0 in IDLE.
- Upper cfg bits beyond CNT_W are ignored. There is no saturation logic; counters wrap only by compare.

## Timing
- Reset values:
  - state IDLE.
  - `psc_cnt`, `per_cnt` and all shadows = 0.
  - `pwm_out`=0, `period_tick`=0, `irq`=0, `cnt_value`=0.
  - After reset, `pwm_out` follows `inv` from the next edge.
- Start latency: `en` sampled high at edge E0 enters RUN with `per_cnt`=0. `pwm_out` shows the first period's level at edge E0+1.
- Period length: exactly `(prescale+1)*(period+1)` clocks between consecutive `period_tick` pulses.
- High time: exactly `(prescale+1)*min(duty, period+1)` clocks.
- Stop latency: `en` sampled low at edge E0 gives `pwm_out`=`inv` at edge E0+1. An in-flight `period_tick` is suppressed.
- Reset: `reset_p` sampled high at any edge, including mid-period, applies reset values on that edge. This overrides `en` and `irq` set.
- Prescale 0: a tick occurs every clock.
- Max values: period = 2^CNT_W-1 is legal; `per_cnt` must not overflow before compare.

## Test plan
- prescale=0, period=9, duty=3, inv=0, en=1:
  - `pwm_out` high 3 clocks, low 7, repeating.
  - `period_tick` pulses every 10 clocks.
  - `cnt_value` sequences 0..9.
- prescale=1, period=4, duty=2:
  - High 4 clocks, low 6 clocks, period 10 clocks.
  - Then inv=1: the waveform inverts on the next edge with no period restart.
- Shadow update: prescale=0, period=9, duty=3 running; write duty=7 at per_cnt=5.
  - The current period keeps 3 high clocks.
  - The next period has 7 high clocks.
- Boundaries, prescale=0, period=9:
  - duty=0: `pwm_out` constantly 0.
  - duty=12: `pwm_out` constantly 1.
  - `period_tick` still pulses every 10 clocks in both cases.
- Interrupt: irq_en=1.
  - `irq` rises with the first `period_tick` and stays high.
  - `irq_clr` coincident with the next `period_tick` leaves `irq`=1.
  - `irq_clr` alone clears it.
  - irq_en=0 gives no new set.
- Disable and reset:
  - en=0 at per_cnt=4: `pwm_out`=inv next edge, `cnt_value`=0, no `period_tick`.
  - Re-enable: the period restarts at 0.
  - `reset_p` pulse mid-RUN: all outputs 0 next edge, and the state returns to IDLE despite en=1 until reset deasserts.
